// File: rtl/sfr_rd_port_pkg.sv
// Shared SFR constants for the data-memory read port and the write-enable
// decoder: SFR addresses, read-port state encoding and address decode helper.
package sfr_rd_port_pkg;

  // SFR addresses in CPU data-memory space
  localparam logic [7:0] SFR_ADDR_OUT = 8'h01;
  localparam logic [7:0] SFR_ADDR_DIR = 8'h02;
  localparam logic [7:0] SFR_ADDR_PIN = 8'h03;
  localparam logic [7:0] SFR_ADDR_CHG = 8'h04;

  // Pending-response source held between the accept cycle and the response cycle
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RESP_SFR = 2'd1,
    ST_RESP_RAM = 2'd2
  } rd_state_t;

  // Which SFR (if any) an address selects
  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_OUT  = 3'd1,
    SEL_DIR  = 3'd2,
    SEL_PIN  = 3'd3,
    SEL_CHG  = 3'd4
  } sfr_sel_t;

  // Map an address onto the SFR it selects; anything else is RAM
  function automatic sfr_sel_t sfr_decode(input logic [7:0] addr);
    sfr_sel_t sel;
    case (addr)
      SFR_ADDR_OUT: sel = SEL_OUT;
      SFR_ADDR_DIR: sel = SEL_DIR;
      SFR_ADDR_PIN: sel = SEL_PIN;
      SFR_ADDR_CHG: sel = SEL_CHG;
      default:      sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  // True when the address lands in the SFR window rather than RAM
  function automatic logic is_sfr(input logic [7:0] addr);
    return sfr_decode(addr) != SEL_NONE;
  endfunction

endpackage

// File: rtl/sfr_rd_port_if.sv
// CPU read bus plus the synchronous RAM read port it fronts.
// The master side is the CPU together with the RAM; the slave side is the
// read port, which decides whether RAM or an SFR answers.
interface sfr_rd_port_if;
  logic [7:0] Address;
  logic       MR;
  logic       RAM_RD_EN;
  logic [7:0] RAM_DATA;
  logic [7:0] RD_DATA;
  logic       RD_VALID;

  modport master (
    output Address,
    output MR,
    output RAM_DATA,
    input  RAM_RD_EN,
    input  RD_DATA,
    input  RD_VALID
  );

  modport slave (
    input  Address,
    input  MR,
    input  RAM_DATA,
    output RAM_RD_EN,
    output RD_DATA,
    output RD_VALID
  );
endinterface

// File: rtl/sfr_pin_sync.sv
// Pin synchronizer: SYNC_STAGES flops per pin, a one-flop-older copy (pin_p)
// of the last stage (pin_s), and the per-bit change vector. Change reporting
// is held off for SYNC_STAGES+1 cycles after reset so the reset zeros being
// flushed out of the chain never look like pin edges.
// SYNC_STAGES is meaningful in the range 2..4.
module sfr_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pin,
  output logic [7:0] pin_s,
  output logic [7:0] pin_chg
);

  localparam int         HOLD_CYCLES = SYNC_STAGES + 1;
  localparam logic [2:0] HOLD_INIT   = 3'(HOLD_CYCLES);

  logic [2:0] hold_reg;
  logic       arm;

  // Count down the post-reset flush window; detection arms at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_reg <= HOLD_INIT;
    end else if (hold_reg != 3'd0) begin
      hold_reg <= hold_reg - 3'd1;
    end
  end

  assign arm = (hold_reg == 3'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      logic [SYNC_STAGES-1:0] chain_reg;
      logic                   prev_reg;

      // Shift the raw pin through the chain; prev_reg trails the last stage
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          chain_reg <= '0;
          prev_reg  <= 1'b0;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin[gi]};
          prev_reg  <= chain_reg[SYNC_STAGES-1];
        end
      end

      assign pin_s[gi]   = chain_reg[SYNC_STAGES-1];
      assign pin_chg[gi] = arm & (chain_reg[SYNC_STAGES-1] ^ prev_reg);
    end
  endgenerate

endmodule

// File: rtl/sfr_rd_port.sv
// CPU data-memory read port. Addresses 0x01..0x04 are answered from the SFR
// block (OUT, DIR, synchronized pins, pin-change flags); every other address
// is forwarded to a synchronous RAM. Every accepted request gets exactly one
// RD_VALID pulse in the following cycle, so back-to-back reads stream.
module sfr_rd_port
  import sfr_rd_port_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic          CLK,
  input  logic          RST_N,
  sfr_rd_port_if.slave  bus,
  input  logic [7:0]    OUT_REG,
  input  logic [7:0]    DIR_REG,
  input  logic [7:0]    PIN,
  output logic          CHG_IRQ
);

  rd_state_t  state_reg;
  rd_state_t  state_next;
  sfr_sel_t   sel;
  logic [7:0] sfr_mux;
  logic [7:0] sfr_data_reg;
  logic       accept_sfr;
  logic       rd_chg;

  logic [7:0] pin_s;
  logic [7:0] pin_chg;
  logic [7:0] chg_reg;
  logic [7:0] chg_next;
  logic       chg_irq_reg;

  sfr_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync (
    .clk     (CLK),
    .rst_n   (RST_N),
    .pin     (PIN),
    .pin_s   (pin_s),
    .pin_chg (pin_chg)
  );

  assign sel           = sfr_decode(bus.Address);
  assign accept_sfr    = bus.MR & (sel != SEL_NONE);
  assign rd_chg        = bus.MR & (sel == SEL_CHG);
  assign bus.RAM_RD_EN = bus.MR & (sel == SEL_NONE);

  // Select the SFR value an accepted request will return next cycle
  always_comb begin
    sfr_mux = 8'h00;
    case (sel)
      SEL_OUT: sfr_mux = OUT_REG;
      SEL_DIR: sfr_mux = DIR_REG;
      SEL_PIN: sfr_mux = pin_s;
      SEL_CHG: sfr_mux = chg_reg;
      default: sfr_mux = 8'h00;
    endcase
  end

  // Next pending source depends only on this cycle's request and decode
  always_comb begin
    state_next = ST_IDLE;
    if (bus.MR) begin
      state_next = (sel == SEL_NONE) ? ST_RESP_RAM : ST_RESP_SFR;
    end
  end

  // Pending-source register; reset drops any response in flight
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the SFR read value in the accept cycle (pre-clear flags for 0x04)
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sfr_data_reg <= 8'h00;
    end else if (accept_sfr) begin
      sfr_data_reg <= sfr_mux;
    end else begin
      sfr_data_reg <= 8'h00;
    end
  end

  // Flag update: clear-on-read first, then new input-pin edges OR in, so a
  // simultaneous edge survives the read that clears its bit
  always_comb begin
    chg_next = (rd_chg ? 8'h00 : chg_reg) | (pin_chg & ~DIR_REG);
  end

  // Flags and the interrupt register; IRQ follows the flags with no extra lag
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      chg_reg     <= 8'h00;
      chg_irq_reg <= 1'b0;
    end else begin
      chg_reg     <= chg_next;
      chg_irq_reg <= |chg_next;
    end
  end

  assign CHG_IRQ = chg_irq_reg;

  // Response outputs; a response coinciding with reset is suppressed and
  // RD_DATA reads zero whenever RD_VALID is low
  always_comb begin
    bus.RD_VALID = 1'b0;
    bus.RD_DATA  = 8'h00;
    if (RST_N) begin
      case (state_reg)
        ST_RESP_SFR: begin
          bus.RD_VALID = 1'b1;
          bus.RD_DATA  = sfr_data_reg;
        end
        ST_RESP_RAM: begin
          bus.RD_VALID = 1'b1;
          bus.RD_DATA  = bus.RAM_DATA;
        end
        default: begin
          bus.RD_VALID = 1'b0;
          bus.RD_DATA  = 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfr_rd_port.sv
// Bench for sfr_rd_port: a directed vector table, hand sequences for the
// multi-cycle flag corners and reset, then randomized traffic checked every
// cycle against a behavioural model built from pin-sample history.
module tb_sfr_rd_port;

  localparam int S = 2;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] OUT_REG;
  logic [7:0] DIR_REG;
  logic [7:0] PIN;
  logic       CHG_IRQ;

  sfr_rd_port_if bus ();

  sfr_rd_port #(.SYNC_STAGES(S)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .bus     (bus),
    .OUT_REG (OUT_REG),
    .DIR_REG (DIR_REG),
    .PIN     (PIN),
    .CHG_IRQ (CHG_IRQ)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;
  int cyc_n   = 0;
  bit chk_en  = 0;

  // observed outputs of the most recent cycle
  logic       obs_valid, obs_ramen, obs_irq;
  logic [7:0] obs_data;

  // reference model state
  int         m_pend  = 0;     // 0 none, 1 sfr, 2 ram
  logic [7:0] m_pdata = 8'h00;
  logic [7:0] m_chg   = 8'h00;
  int         m_n     = 0;     // edges since reset release
  logic [7:0] m_q[$];          // pin samples since release, newest last

  typedef struct {
    bit         rst_n;
    bit         mr;
    logic [7:0] addr;
    logic [7:0] ram;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ramen;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %02h expected %02h", nm, cyc_n, act, exp);
  endtask

  function automatic logic [7:0] samp(input int back);
    if (m_q.size() > back) return m_q[m_q.size() - 1 - back];
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_pin_s();
    return (m_n >= S) ? samp(S - 1) : 8'h00;
  endfunction

  function automatic logic [7:0] m_pin_p();
    return (m_n >= S + 1) ? samp(S) : 8'h00;
  endfunction

  function automatic bit m_is_sfr(input logic [7:0] a);
    return (a >= 8'h01) && (a <= 8'h04);
  endfunction

  // advance the model across one rising edge using the currently driven inputs
  task automatic model_edge();
    logic [7:0] set_v, pre, v;
    if (!RST_N) begin
      m_pend = 0; m_pdata = 8'h00; m_chg = 8'h00; m_n = 0; m_q.delete();
    end else begin
      set_v = (m_n >= S + 1) ? ((m_pin_s() ^ m_pin_p()) & ~DIR_REG) : 8'h00;
      pre = m_chg;
      if (bus.MR) begin
        if (m_is_sfr(bus.Address)) begin
          case (bus.Address)
            8'h01:   v = OUT_REG;
            8'h02:   v = DIR_REG;
            8'h03:   v = m_pin_s();
            default: v = pre;
          endcase
          m_pend = 1; m_pdata = v;
        end else begin
          m_pend = 2;
        end
      end else begin
        m_pend = 0;
      end
      if (bus.MR && bus.Address == 8'h04) m_chg = 8'h00;
      m_chg = m_chg | set_v;
      m_q.push_back(PIN);
      if (m_q.size() > 8) void'(m_q.pop_front());
      if (m_n < 50) m_n++;
    end
  endtask

  // one clock cycle: observe, compare with model, step model, cross edge
  task automatic cyc();
    logic       e_valid, e_ramen, e_irq;
    logic [7:0] e_data;
    #1;
    obs_valid = bus.RD_VALID; obs_data = bus.RD_DATA;
    obs_ramen = bus.RAM_RD_EN; obs_irq = CHG_IRQ;
    if (chk_en) begin
      e_valid = (m_pend != 0) && RST_N;
      e_data  = !e_valid ? 8'h00 : (m_pend == 1 ? m_pdata : bus.RAM_DATA);
      e_ramen = bus.MR && !m_is_sfr(bus.Address);
      e_irq   = (m_chg != 8'h00);
      chk("model_rd_valid", {7'd0, obs_valid}, {7'd0, e_valid});
      chk("model_rd_data", obs_data, e_data);
      chk("model_ram_rd_en", {7'd0, obs_ramen}, {7'd0, e_ramen});
      chk("model_chg_irq", {7'd0, obs_irq}, {7'd0, e_irq});
    end
    model_edge();
    @(posedge CLK);
    #1;
    cyc_n++;
  endtask

  task automatic req(input bit mr, input logic [7:0] a);
    bus.MR = mr; bus.Address = a; cyc();
  endtask

  initial begin
    RST_N = 1'b0; bus.MR = 1'b0; bus.Address = 8'h00; bus.RAM_DATA = 8'h00;
    OUT_REG = 8'h5A; DIR_REG = 8'hA5; PIN = 8'h3C;

    vecs[0]  = '{0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0};
    vecs[1]  = '{1, 1, 8'h02, 8'h00, 0, 8'h00, 0, 0};
    vecs[2]  = '{1, 0, 8'h02, 8'h00, 1, 8'hA5, 0, 0};
    vecs[3]  = '{1, 1, 8'h40, 8'h00, 0, 8'h00, 1, 0};
    vecs[4]  = '{1, 0, 8'h00, 8'h3C, 1, 8'h3C, 0, 0};
    vecs[5]  = '{1, 1, 8'h01, 8'h00, 0, 8'h00, 0, 0};
    vecs[6]  = '{1, 1, 8'h40, 8'h00, 1, 8'h5A, 1, 0};
    vecs[7]  = '{1, 1, 8'h03, 8'h77, 1, 8'h77, 0, 0};
    vecs[8]  = '{1, 0, 8'h00, 8'h99, 1, 8'h3C, 0, 0};
    vecs[9]  = '{1, 1, 8'h04, 8'h00, 0, 8'h00, 0, 0};
    vecs[10] = '{1, 0, 8'h00, 8'h00, 1, 8'h00, 0, 0};
    vecs[11] = '{1, 1, 8'h00, 8'h00, 0, 8'h00, 1, 0};
    vecs[12] = '{1, 1, 8'h05, 8'h11, 1, 8'h11, 1, 0};
    vecs[13] = '{1, 1, 8'hFF, 8'h22, 1, 8'h22, 1, 0};
    vecs[14] = '{1, 0, 8'h00, 8'h33, 1, 8'h33, 0, 0};
    vecs[15] = '{1, 0, 8'h00, 8'h44, 0, 8'h00, 0, 0};

    @(posedge CLK); #1;
    cyc(); cyc();
    chk_en = 1;

    // directed table: reset state, SFR/RAM reads, streaming, map boundaries
    for (int i = 0; i < 16; i++) begin
      RST_N = vecs[i].rst_n; bus.MR = vecs[i].mr;
      bus.Address = vecs[i].addr; bus.RAM_DATA = vecs[i].ram;
      cyc();
      chk($sformatf("vec%0d_valid", i), {7'd0, obs_valid}, {7'd0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_data", i), obs_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_ramen", i), {7'd0, obs_ramen}, {7'd0, vecs[i].exp_ramen});
      chk($sformatf("vec%0d_irq", i), {7'd0, obs_irq}, {7'd0, vecs[i].exp_irq});
    end

    // flags: DIR=0x0F, settle, clear, then PIN 0x00->0xFF
    DIR_REG = 8'h0F; PIN = 8'h00; bus.RAM_DATA = 8'h00;
    for (int k = 0; k < 6; k++) req(0, 8'h00);
    req(1, 8'h04);
    req(0, 8'h00);
    chk("settle_clear_data", obs_data, 8'h30);
    chk("settle_clear_irq", {7'd0, obs_irq}, 8'h00);
    PIN = 8'hFF;
    for (int k = 0; k <= S + 1; k++) begin
      req(0, 8'h00);
      if (k == S)     chk("chg_irq_before", {7'd0, obs_irq}, 8'h00);
      if (k == S + 1) chk("chg_irq_after", {7'd0, obs_irq}, 8'h01);
    end
    req(1, 8'h04);
    req(0, 8'h00);
    chk("chg_read_f0", obs_data, 8'hF0);
    chk("chg_irq_cleared", {7'd0, obs_irq}, 8'h00);
    req(1, 8'h04);
    req(0, 8'h00);
    chk("chg_read_empty", obs_data, 8'h00);

    // set beats clear: PIN[4] edge lands in the cycle a 0x04 read is accepted
    PIN = 8'h7F;
    for (int k = 0; k < 5; k++) req(0, 8'h00);
    PIN = 8'h6F;
    for (int k = 0; k < S; k++) req(0, 8'h00);
    req(1, 8'h04);
    req(1, 8'h04);
    chk("race_old_flags", obs_data, 8'h80);
    chk("race_irq_kept", {7'd0, obs_irq}, 8'h01);
    req(0, 8'h00);
    chk("race_bit4_kept", obs_data, 8'h10);
    chk("race_irq_done", {7'd0, obs_irq}, 8'h00);

    // reset in the cycle after an accept drops the response
    PIN = 8'h4F;
    for (int k = 0; k < 5; k++) req(0, 8'h00);
    chk("pre_rst_irq", {7'd0, obs_irq}, 8'h01);
    req(1, 8'h02);
    RST_N = 1'b0;
    req(0, 8'h00);
    chk("rst_mid_valid", {7'd0, obs_valid}, 8'h00);
    chk("rst_mid_data", obs_data, 8'h00);
    RST_N = 1'b1;
    req(0, 8'h00);
    chk("rst_rel_valid", {7'd0, obs_valid}, 8'h00);
    chk("rst_rel_irq", {7'd0, obs_irq}, 8'h00);
    req(0, 8'h00);
    chk("rst_rel_valid2", {7'd0, obs_valid}, 8'h00);

    // randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      RST_N = ($urandom_range(0, 199) != 0);
      bus.MR = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       bus.Address = 8'($urandom_range(0, 5));
        1:       bus.Address = 8'h40;
        2:       bus.Address = 8'($urandom);
        default: bus.Address = 8'h04;
      endcase
      OUT_REG = 8'($urandom);
      bus.RAM_DATA = 8'($urandom);
      if ($urandom_range(0, 5) == 0) PIN = PIN ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) DIR_REG = 8'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
